// File: rtl/state_dump_ctrl_if.sv
// Dump stream channel for state_dump_ctrl: valid/ready word stream tagged with source and index.
interface state_dump_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              dump_valid;
  logic [DATA_W-1:0] dump_data;
  logic [1:0]        dump_src;
  logic [7:0]        dump_idx;
  logic              dump_ready;

  modport master (
    output dump_valid, dump_data, dump_src, dump_idx,
    input  dump_ready
  );

  modport slave (
    input  dump_valid, dump_data, dump_src, dump_idx,
    output dump_ready
  );
endinterface

// File: rtl/state_dump_ctrl.sv
// Hardware state-dump engine: on PC trigger, streams DM (big-endian words) then RF words.
// Optional trailing checksum word is built when DUMP_CHECKSUM_EN is defined.
module state_dump_ctrl #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DM_BYTES = 256,
  parameter int unsigned       RF_DEPTH = 32,
  parameter logic [ADDR_W-1:0] TRIG_PC  = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_arm,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [ADDR_W-1:0] o_dm_addr,
  input  logic [7:0]        i_dm_rdata,
  output logic [4:0]        o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_rdata,
  state_dump_ctrl_if.master dump,
  output logic              o_busy,
  output logic              o_done
);
  localparam int unsigned DM_WORDS = DM_BYTES / 4;
  localparam int unsigned DM_IW    = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
  localparam int unsigned RF_IW    = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
  localparam int unsigned IDX_W    = (DM_IW > RF_IW) ? DM_IW : RF_IW;
  localparam logic [IDX_W-1:0] DM_LAST = IDX_W'(DM_WORDS - 1);
  localparam logic [IDX_W-1:0] RF_LAST = IDX_W'(RF_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DM_RD,
    S_DM_OUT,
    S_RF_RD,
    S_RF_OUT,
`ifdef DUMP_CHECKSUM_EN
    S_SUM_OUT,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        byte_q, byte_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d, dm_addr_rd;
  logic [4:0]        rf_addr_q, rf_addr_d, rf_addr_rd;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      byte_q    <= '0;
      data_q    <= '0;
      dm_addr_q <= '0;
      rf_addr_q <= '0;
`ifdef DUMP_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      data_q    <= data_d;
      dm_addr_q <= dm_addr_d;
      rf_addr_q <= rf_addr_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  // Read addresses are live in the read states and frozen from the last read elsewhere.
  assign dm_addr_rd = ADDR_W'({idx_q, byte_q});
  assign rf_addr_rd = 5'(idx_q);
  assign o_dm_addr  = (state_q == S_DM_RD) ? dm_addr_rd : dm_addr_q;
  assign o_rf_addr  = (state_q == S_RF_RD) ? rf_addr_rd : rf_addr_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    data_d    = data_q;
    dm_addr_d = dm_addr_q;
    rf_addr_d = rf_addr_q;
`ifdef DUMP_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (i_pc == TRIG_PC) begin
          state_d = S_DM_RD;
          idx_d   = '0;
          byte_d  = '0;
`ifdef DUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_DM_RD: begin
        // Shift bytes in at the bottom so byte 0 ends up in the top lane.
        data_d    = {data_q[DATA_W-9:0], i_dm_rdata};
        dm_addr_d = dm_addr_rd;
        byte_d    = byte_q + 2'd1;
        if (byte_q == 2'd3) state_d = S_DM_OUT;
      end
      S_DM_OUT: begin
        if (dump.dump_ready) begin
`ifdef DUMP_CHECKSUM_EN
          sum_d = sum_q + data_q;
`endif
          if (idx_q == DM_LAST) begin
            idx_d   = '0;
            state_d = S_RF_RD;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_DM_RD;
          end
        end
      end
      S_RF_RD: begin
        data_d    = i_rf_rdata;
        rf_addr_d = rf_addr_rd;
        state_d   = S_RF_OUT;
      end
      S_RF_OUT: begin
        if (dump.dump_ready) begin
`ifdef DUMP_CHECKSUM_EN
          sum_d = sum_q + data_q;
`endif
          if (idx_q == RF_LAST) begin
`ifdef DUMP_CHECKSUM_EN
            state_d = S_SUM_OUT;
`else
            state_d = S_DONE;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RF_RD;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_SUM_OUT: begin
        if (dump.dump_ready) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dump.dump_valid = 1'b0;
    dump.dump_src   = 2'b00;
    dump.dump_data  = data_q;
    dump.dump_idx   = 8'(idx_q);
    case (state_q)
      S_DM_OUT: dump.dump_valid = 1'b1;
      S_RF_OUT: begin
        dump.dump_valid = 1'b1;
        dump.dump_src   = 2'b01;
      end
`ifdef DUMP_CHECKSUM_EN
      S_SUM_OUT: begin
        dump.dump_valid = 1'b1;
        dump.dump_src   = 2'b10;
        dump.dump_data  = sum_q;
        dump.dump_idx   = '0;
      end
`endif
      default: ;
    endcase
  end

  assign o_busy = (state_q != S_IDLE) && (state_q != S_ARMED) && (state_q != S_DONE);
  assign o_done = (state_q == S_DONE);
endmodule

// File: tb/tb_state_dump_ctrl.sv
// Directed self-checking bench for state_dump_ctrl (honours DUMP_CHECKSUM_EN when defined).
module tb_state_dump_ctrl;
`ifdef DUMP_CHECKSUM_EN
  localparam int NW = 97;
`else
  localparam int NW = 96;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic [31:0] pc  = '0;
  logic [31:0] dm_addr;
  logic [7:0]  dm_rdata;
  logic [4:0]  rf_addr;
  logic [31:0] rf_rdata;
  logic        busy, done;

  logic [7:0]  dm_mem [256];
  logic [31:0] rf_mem [32];
  logic [41:0] got    [128];
  int          wcyc   [128];
  int          n_cmp = 0;
  int          n_err = 0;
  int          words_seen;
  logic        any_act;

  state_dump_ctrl_if #(.DATA_W(32)) dif ();

  state_dump_ctrl #(
    .DATA_W(32), .ADDR_W(32), .DM_BYTES(256), .RF_DEPTH(32), .TRIG_PC(32'h0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_pc(pc),
    .o_dm_addr(dm_addr), .i_dm_rdata(dm_rdata),
    .o_rf_addr(rf_addr), .i_rf_rdata(rf_rdata),
    .dump(dif),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  assign dm_rdata = dm_mem[dm_addr[7:0]];
  assign rf_rdata = rf_mem[rf_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] exp_word(input int w);
    logic [31:0] s;
    if (w < 64)
      return {2'b00, 8'(w), dm_mem[4*w], dm_mem[4*w+1], dm_mem[4*w+2], dm_mem[4*w+3]};
    if (w < 96)
      return {2'b01, 8'(w - 64), rf_mem[w - 64]};
    s = '0;
    for (int i = 0; i < 96; i++) s = s + exp_word(i)[31:0];
    return {2'b10, 8'h00, s};
  endfunction

  // Arm, then accept words with ready high; optional 7-cycle stall on one word, optional early stop.
  task automatic run_dump(input int n, input int stall_w, input int stop_at);
    int w;
    int cyc;
    logic [41:0] e;
    w   = 0;
    cyc = 0;
    dif.dump_ready = 1'b1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    while (w < n && w != stop_at && cyc < 2000) begin
      if (dif.dump_valid) begin
        e = exp_word(w);
        got[w]  = {dif.dump_src, dif.dump_idx, dif.dump_data};
        wcyc[w] = cyc;
        chk($sformatf("word%0d", w), 64'(got[w]), 64'(e));
        if (w == stall_w) begin
          dif.dump_ready = 1'b0;
          repeat (7) begin
            step();
            cyc++;
            chk("stall_hold", {31'b0, dif.dump_valid, dif.dump_data}, {31'b0, 1'b1, e[31:0]});
          end
        end
        dif.dump_ready = 1'b1;
        step();
        cyc++;
        w++;
      end else begin
        step();
        cyc++;
      end
    end
    words_seen = w;
  endtask

  task automatic fill_basic();
    for (int n = 0; n < 256; n++) dm_mem[n] = 8'(n);
    for (int r = 0; r < 32; r++) rf_mem[r] = 32'(r) * 32'h11111111;
  endtask

  task automatic watch_idle(input int cycles);
    any_act = 1'b0;
    repeat (cycles) begin
      step();
      any_act = any_act | dif.dump_valid | busy;
    end
  endtask

  initial begin
    fill_basic();
    dif.dump_ready = 1'b1;

    // Asynchronous reset between clock edges
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 64'(dif.dump_valid), 64'd0);
    chk("rst_busy_done", {62'b0, busy, done}, 64'd0);
    chk("rst_addrs", {27'b0, rf_addr, dm_addr}, 64'd0);
    chk("rst_stream", 64'({dif.dump_src, dif.dump_idx, dif.dump_data}), 64'd0);
    step();
    step();
    rst = 1'b0;

    // PC at trigger while unarmed
    pc = 32'h0;
    watch_idle(12);
    chk("idle_no_dump", 64'(any_act), 64'd0);

    // Basic dump
    run_dump(NW, -1, -1);
    chk("basic_count", 64'(words_seen), 64'(NW));
    chk("first_word", 64'(got[0]), 64'({2'b00, 8'h00, 32'h00010203}));
    chk("first_latency", 64'(wcyc[0]), 64'd5);
    chk("dm_spacing", 64'(wcyc[1] - wcyc[0]), 64'd5);
    chk("dm_to_rf_spacing", 64'(wcyc[64] - wcyc[63]), 64'd2);
    chk("rf_spacing", 64'(wcyc[65] - wcyc[64]), 64'd2);
    chk("rf5_word", 64'(got[69]), 64'({2'b01, 8'd5, 32'h55555555}));
    step();
    chk("done_after_dump", {62'b0, busy, done}, 64'd1);

    // Trigger PC while DONE must not retrigger
    watch_idle(12);
    chk("done_no_retrigger", 64'(any_act), 64'd0);
    chk("done_held", 64'(done), 64'd1);

    // Backpressure on DM word 3
    run_dump(NW, 3, -1);
    chk("bp_count", 64'(words_seen), 64'(NW));
    chk("bp_word3", 64'(got[3][31:0]), 64'h0C0D0E0F);
    chk("bp_word4", 64'(got[4]), 64'({2'b00, 8'd4, 32'h10111213}));

    // Armed but PC never reaches the trigger
    pc  = 32'h4;
    arm = 1'b1;
    step();
    arm = 1'b0;
    watch_idle(20);
    chk("no_trigger", 64'(any_act), 64'd0);
    chk("no_trigger_done", 64'(done), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    pc  = 32'h0;

    // Reset while RF word 10 is being offered
    run_dump(NW, -1, 74);
    chk("pre_rst_count", 64'(words_seen), 64'd74);
    dif.dump_ready = 1'b0;
    step();
    chk("rf10_offered", 64'({dif.dump_valid, dif.dump_src, dif.dump_idx, dif.dump_data}),
        64'({1'b1, 2'b01, 8'd10, 32'hAAAAAAAA}));
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(dif.dump_valid), 64'd0);
    chk("midrst_busy_done", {62'b0, busy, done}, 64'd0);
    chk("midrst_addrs", {27'b0, rf_addr, dm_addr}, 64'd0);
    step();
    rst = 1'b0;
    dif.dump_ready = 1'b1;
    watch_idle(10);
    chk("midrst_quiet", 64'(any_act), 64'd0);
    run_dump(NW, -1, -1);
    chk("restart_count", 64'(words_seen), 64'(NW));
    chk("restart_first", 64'(got[0]), 64'({2'b00, 8'h00, 32'h00010203}));

`ifdef DUMP_CHECKSUM_EN
    for (int n = 0; n < 256; n++) dm_mem[n] = 8'h00;
    for (int r = 0; r < 32; r++) rf_mem[r] = 32'h1;
    run_dump(NW, -1, -1);
    chk("sum_count", 64'(words_seen), 64'(NW));
    chk("sum_word", 64'(got[96]), 64'({2'b10, 8'h00, 32'h00000020}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
